// File: rtl/y_pc_fetch_if.sv
// Fetch-side bundle for the PC stage: the downstream handshake, the next-PC
// controls in, and the presented PC, PC+4, valid flag and accept count out.
interface y_pc_fetch_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ready;
  logic             branch;
  logic             zero;
  logic [15:0]      imm;
  logic             jump;
  logic [25:0]      jtarget;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             valid;
  logic [31:0]      count;

  modport master (
    output ready, branch, zero, imm, jump, jtarget,
    input  pc, pc_plus4, valid, count
  );

  modport slave (
    input  ready, branch, zero, imm, jump, jtarget,
    output pc, pc_plus4, valid, count
  );
endinterface

// File: rtl/y_pc_fetch.sv
// Program-counter stage: holds the PC, presents it with PC+4, and advances it
// through the sequential / branch / jump select chain on each accepted cycle.
module y_pc_fetch #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0080
) (
  input  logic         clk,
  input  logic         reset,
  y_pc_fetch_if.slave  bus
);

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      count_q, count_d;

  logic             advance;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] jump_pc;
  logic [WIDTH-1:0] next_pc;

  assign seq_pc    = pc_q + WIDTH'(4);
  assign imm_ext   = {{(WIDTH-16){bus.imm[15]}}, bus.imm};
  assign branch_pc = seq_pc + {imm_ext[WIDTH-3:0], 2'b00};
  assign jump_pc   = {seq_pc[WIDTH-1:WIDTH-4], bus.jtarget, 2'b00};

  // Jump outranks a taken branch, so zero is irrelevant whenever jump is set.
  always_comb begin
    next_pc = seq_pc;
    if (bus.jump) begin
      next_pc = jump_pc;
    end else if (bus.branch && bus.zero) begin
      next_pc = branch_pc;
    end
  end

  assign advance = (state_q == RUN) && bus.ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (advance) begin
      pc_d    = next_pc;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = seq_pc;
  assign bus.valid    = (state_q == RUN);
  assign bus.count    = count_q;

endmodule

// File: tb/tb_y_pc_fetch.sv
// Self-checking bench for y_pc_fetch: directed test-plan steps plus a random
// run against a behavioural next-PC model, and two extra instances for the
// wrap-around and jump-priority cases that need a different reset PC.
module tb_y_pc_fetch;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  y_pc_fetch_if #(.WIDTH(32)) bus0 ();
  y_pc_fetch_if #(.WIDTH(32)) bus1 ();
  y_pc_fetch_if #(.WIDTH(32)) bus2 ();

  y_pc_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0080)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  y_pc_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  y_pc_fetch #(.WIDTH(32), .RESET_PC(32'h1000_0040)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br,
                                           input logic z, input logic [15:0] imm,
                                           input logic j, input logic [25:0] jt);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return {seq[31:28], jt, 2'b00};
    if (br && z) return seq + 32'($signed(imm)) * 32'd4;
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model for the coming edge, clock once, then compare dut0.
  task automatic step();
    if (reset) begin
      m_pc = 32'h80; m_cnt = '0; m_valid = 1'b0;
    end else begin
      if (m_valid && bus0.ready) begin
        m_pc  = ref_next(m_pc, bus0.branch, bus0.zero, bus0.imm, bus0.jump, bus0.jtarget);
        m_cnt = m_cnt + 32'd1;
      end
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check("model_pc", bus0.pc, m_pc);
    check("model_pc_plus4", bus0.pc_plus4, m_pc + 32'd4);
    check("model_valid", {31'b0, bus0.valid}, {31'b0, m_valid});
    check("model_count", bus0.count, m_cnt);
  endtask

  task automatic ctl(input logic rdy, input logic br, input logic z,
                     input logic [15:0] imm, input logic j, input logic [25:0] jt);
    bus0.ready = rdy; bus0.branch = br; bus0.zero = z;
    bus0.imm = imm; bus0.jump = j; bus0.jtarget = jt;
  endtask

  initial begin
    reset = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    bus1.ready = 1'b0; bus1.branch = 1'b0; bus1.zero = 1'b0;
    bus1.imm = '0; bus1.jump = 1'b0; bus1.jtarget = '0;
    bus2.ready = 1'b0; bus2.branch = 1'b0; bus2.zero = 1'b0;
    bus2.imm = '0; bus2.jump = 1'b0; bus2.jtarget = '0;

    // Reset for two cycles, then sequential run.
    step();
    step();
    check("reset_pc", bus0.pc, 32'h80);
    check("reset_valid", {31'b0, bus0.valid}, 32'd0);
    check("reset_count", bus0.count, 32'd0);
    reset = 1'b0;
    check("boot_valid", {31'b0, bus0.valid}, 32'd0);
    step();
    check("seq0_pc", bus0.pc, 32'h80);
    check("seq0_count", bus0.count, 32'd0);
    step();
    check("seq1_pc", bus0.pc, 32'h84);
    step();
    check("seq2_pc", bus0.pc, 32'h88);
    check("seq2_count", bus0.count, 32'd2);

    // Stall with control inputs toggling underneath.
    for (int unsigned i = 0; i < 3; i++) begin
      ctl(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 26'($urandom));
      step();
      check("stall_pc", bus0.pc, 32'h88);
      check("stall_count", bus0.count, 32'd2);
      check("stall_valid", {31'b0, bus0.valid}, 32'd1);
    end
    ctl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    check("unstall_pc", bus0.pc, 32'h8C);

    // Branch back to 0x88, then taken/not-taken from 0x88.
    ctl(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 26'h0);
    step();
    check("branch_to_88", bus0.pc, 32'h88);
    step();
    check("branch_taken", bus0.pc, 32'h84);
    ctl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    check("seq_to_88", bus0.pc, 32'h88);
    ctl(1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 26'h0);
    step();
    check("branch_not_taken", bus0.pc, 32'h8C);

    // Randomised run with occasional resets.
    for (int unsigned i = 0; i < 300; i++) begin
      reset = ($urandom_range(31) == 0);
      ctl(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
          16'($urandom), ($urandom_range(5) == 0), 26'($urandom));
      step();
    end

    // Mid-run reset after five accepts, with jump held high.
    reset = 1'b0;
    ctl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    step();
    for (int unsigned i = 0; i < 5; i++) step();
    check("pre_reset_valid", {31'b0, bus0.valid}, 32'd1);
    reset = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF);
    step();
    check("midreset_pc", bus0.pc, 32'h80);
    check("midreset_count", bus0.count, 32'd0);
    check("midreset_valid", {31'b0, bus0.valid}, 32'd0);
    reset = 1'b0;
    step();
    check("resume_boot_pc", bus0.pc, 32'h80);
    check("resume_valid", {31'b0, bus0.valid}, 32'd1);
    ctl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step();
    check("resume_pc", bus0.pc, 32'h84);
    check("resume_count", bus0.count, 32'd1);

    // Wrap-around and jump priority on the other instances (held since reset).
    check("wrap_hold_pc", bus1.pc, 32'hFFFF_FFFC);
    check("jprio_hold_pc", bus2.pc, 32'h1000_0040);
    bus1.ready = 1'b1;
    bus2.ready = 1'b1; bus2.jump = 1'b1; bus2.jtarget = 26'h20;
    bus2.branch = 1'b1; bus2.zero = 1'b1; bus2.imm = 16'h7FFF;
    step();
    check("wrap_pc", bus1.pc, 32'h0000_0000);
    check("wrap_pc_plus4", bus1.pc_plus4, 32'h0000_0004);
    check("jprio_pc", bus2.pc, 32'h1000_0080);
    check("jprio_count", bus2.count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y_pc_fetch.md
# y_pc_fetch

Sequential program-counter stage for the single-cycle datapath. It holds the current PC and presents it, with PC+4, to the fetch path. Each time the downstream stage accepts it, the PC advances to the next address. That next address is selected by the same 2:1 mux chain as the rest of the datapath: sequential, taken branch, or jump. The block sits directly upstream of instruction memory and the next-PC muxes, and produces the select-driven address they consume.

## Interface
- `WIDTH`, 32: address width; must be 32 (jump concatenation assumes it).
- `RESET_PC`, 32'h0000_0080: PC value loaded on reset; must be word-aligned (bits [1:0] = 0).

- `clk`  input  1  rising-edge clock; one clock domain.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `ready`  input  1  downstream accepts the presented PC this cycle.
- `branch`  input  1  current instruction is a conditional branch.
- `zero`  input  1  ALU zero flag for the current instruction.
- `imm`  input  16  signed branch offset in words.
- `jump`  input  1  current instruction is a jump.
- `jtarget`  input  26  jump word-address field.
- `pc`  output  WIDTH  current PC (registered).
- `pc_plus4`  output  WIDTH  `pc + 4`, combinational from `pc`.
- `valid`  output  1  `pc` is presented for fetch (registered).
- `count`  output  32  number of accepted PCs since reset (registered).

## Operation
- FSM states: BOOT and RUN.
  - Reset forces BOOT.
  - BOOT → RUN unconditionally on the next edge.
  - RUN stays in RUN until reset.
  - `valid` = 1 exactly in RUN.
- Accept condition: `advance = valid & ready`. Registers update only on `advance`; otherwise `pc` and `count` hold.
- Next-PC selection, in priority order:
  1. `jump`=1 → `{pc_plus4[31:28], jtarget, 2'b00}`.
  2. `branch & zero` = 1 → `pc_plus4 + (sign_extend(imm) << 2)`.
  3. Otherwise → `pc_plus4`.
- Arithmetic:
  - All sums are modulo 2^32; overflow and underflow wrap silently.
  - `imm` is sign-extended to 32 bits before the 2-bit left shift.
- `jump` and `branch` both high: jump wins, and `zero` is ignored.
- `branch` high with `zero`=0: sequential PC.
- `branch`, `zero`, `imm`, `jump`, `jtarget` are don't-care when `advance`=0.
- `count` increments by 1 on each `advance` and wraps from 0xFFFFFFFF to 0.
- Every produced PC is word-aligned by construction; no alignment checking is done.

## Timing
- Reset values, after the edge at which `reset`=1:
  - `pc` = RESET_PC
  - `pc_plus4` = RESET_PC+4
  - `valid` = 0
  - `count` = 0
  - state = BOOT
- `reset` overrides `advance` on the same edge.
- Reset asserted mid-run takes effect at the next edge, regardless of `ready`.
- First cycle after reset deasserts: `valid`=0 (BOOT). `valid`=1 from the following edge onward.
- Latency: a PC accepted at edge N is replaced by its successor visible right after edge N. Sustained throughput is one PC per cycle while `ready`=1.
- Stall: `ready`=0 holds `pc` and `count` for any number of cycles. `valid` stays 1 while stalled, and the held `pc` must not change.
- Control inputs are sampled only at the accepting edge. Combinational changes while stalled have no effect.
- `pc_plus4` follows `pc` with no added register stage.

## Test plan
- Reset, sequential run:
  - Stimulus: `reset`=1 for 2 cycles, then release with `ready`=1.
  - Required: during reset, `pc`=0x80, `valid`=0, `count`=0. Next cycle `valid`=0 (BOOT). Then `pc` = 0x80, 0x84, 0x88 on successive cycles, with `count` = 0, 1, 2.
- Stall:
  - Stimulus: at `pc`=0x88, `ready`=0 for 3 cycles, then `ready`=1.
  - Required: `pc` stays 0x88 and `count` holds for 3 cycles; next edge `pc`=0x8C.
- Branch:
  - Stimulus: at `pc`=0x88, `branch`=1, `imm`=16'hFFFE.
  - Required: with `zero`=1, next `pc`=0x84. Repeating with `zero`=0 gives next `pc`=0x8C.
- Jump priority:
  - Stimulus: at `pc`=0x1000_0040, `jump`=1, `jtarget`=26'h20, and simultaneously `branch`=1, `zero`=1.
  - Required: next `pc`=0x1000_0080.
- Wrap-around:
  - Stimulus: force `pc` to 0xFFFF_FFFC (via `RESET_PC`=0xFFFF_FFFC), sequential advance.
  - Required: next `pc`=0x0000_0000 and `pc_plus4`=0x4.
- Mid-run reset:
  - Stimulus: after 5 accepts, assert `reset` for one cycle with `ready`=1 and `jump`=1.
  - Required: `pc`=0x80, `count`=0, `valid`=0; then BOOT for one cycle, then normal resumption.
